// File: rtl/riscv_mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch and load/store, one transaction
// in flight at a time. Define RISCV_MEM_ARB_PERF_EN to add the conflict_cnt_o counter.
module riscv_mem_port_arbiter #(
    parameter int unsigned ADDR_W        = 32,
    parameter int unsigned DATA_W        = 32,
    parameter int unsigned MAX_LS_STREAK = 4
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                if_req_i,
    input  logic [ADDR_W-1:0]   if_addr_i,
    input  logic                if_flush_i,
    output logic                if_gnt_o,
    output logic                if_rvalid_o,
    output logic [DATA_W-1:0]   if_rdata_o,
    input  logic                ls_req_i,
    input  logic                ls_we_i,
    input  logic [DATA_W/8-1:0] ls_be_i,
    input  logic [ADDR_W-1:0]   ls_addr_i,
    input  logic [DATA_W-1:0]   ls_wdata_i,
    output logic                ls_gnt_o,
    output logic                ls_rvalid_o,
    output logic [DATA_W-1:0]   ls_rdata_o,
    output logic                mem_req_o,
    output logic                mem_we_o,
    output logic [DATA_W/8-1:0] mem_be_o,
    output logic [ADDR_W-1:0]   mem_addr_o,
    output logic [DATA_W-1:0]   mem_wdata_o,
    input  logic                mem_gnt_i,
    input  logic                mem_rvalid_i,
    input  logic [DATA_W-1:0]   mem_rdata_i,
    output logic                busy_o
`ifdef RISCV_MEM_ARB_PERF_EN
    ,
    output logic [31:0]         conflict_cnt_o
`endif
);

    localparam int unsigned STREAK_W = $clog2(MAX_LS_STREAK + 1);

    typedef enum logic [1:0] {StIdle, StReq, StWait} state_e;

    state_e                state_q;
    logic                  owner_ls_q;
    logic                  drop_q;
    logic                  mem_req_q;
    logic                  we_q;
    logic [DATA_W/8-1:0]   be_q;
    logic [ADDR_W-1:0]     addr_q;
    logic [DATA_W-1:0]     wdata_q;
    logic [STREAK_W-1:0]   streak_q;

    logic idle, if_cand, streak_full, ls_win, if_win, resp;

    assign idle        = (state_q == StIdle);
    assign if_cand     = if_req_i & ~if_flush_i;
    assign streak_full = (streak_q == STREAK_W'(MAX_LS_STREAK));
    // LS has priority; a waiting fetch only overtakes it once the streak limit is reached.
    assign ls_win      = idle & ls_req_i & ~(if_cand & streak_full);
    assign if_win      = idle & if_cand & ~ls_win;

    // Gate with rst_ni so grants/responses drop the instant reset asserts.
    assign ls_gnt_o    = ls_win & rst_ni;
    assign if_gnt_o    = if_win & rst_ni;
    assign resp        = (state_q == StWait) & mem_rvalid_i & rst_ni;
    assign ls_rvalid_o = resp & owner_ls_q;
    assign if_rvalid_o = resp & ~owner_ls_q & ~drop_q & ~if_flush_i;
    assign ls_rdata_o  = ls_rvalid_o ? mem_rdata_i : '0;
    assign if_rdata_o  = if_rvalid_o ? mem_rdata_i : '0;

    assign mem_req_o   = mem_req_q;
    assign mem_we_o    = we_q;
    assign mem_be_o    = be_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;
    assign busy_o      = ~idle;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            owner_ls_q <= 1'b0;
            drop_q     <= 1'b0;
            mem_req_q  <= 1'b0;
            we_q       <= 1'b0;
            be_q       <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            streak_q   <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    drop_q <= 1'b0;
                    if (ls_win) begin
                        state_q    <= StReq;
                        mem_req_q  <= 1'b1;
                        owner_ls_q <= 1'b1;
                        we_q       <= ls_we_i;
                        be_q       <= ls_be_i;
                        addr_q     <= ls_addr_i;
                        wdata_q    <= ls_wdata_i;
                        if (!if_req_i) begin
                            streak_q <= '0;
                        end else if (!streak_full) begin
                            streak_q <= streak_q + STREAK_W'(1);
                        end
                    end else if (if_win) begin
                        state_q    <= StReq;
                        mem_req_q  <= 1'b1;
                        owner_ls_q <= 1'b0;
                        we_q       <= 1'b0;
                        be_q       <= '1;
                        addr_q     <= if_addr_i;
                        wdata_q    <= '0;
                        streak_q   <= '0;
                    end
                end
                StReq: begin
                    // A flushed fetch still completes on the memory side; only its data is dropped.
                    if (if_flush_i && !owner_ls_q) drop_q <= 1'b1;
                    if (mem_gnt_i) begin
                        state_q   <= StWait;
                        mem_req_q <= 1'b0;
                    end
                end
                StWait: begin
                    if (if_flush_i && !owner_ls_q) drop_q <= 1'b1;
                    if (mem_rvalid_i) state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

`ifdef RISCV_MEM_ARB_PERF_EN
    logic [31:0] conflict_cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            conflict_cnt_q <= '0;
        end else if (idle && if_req_i && ls_req_i) begin
            conflict_cnt_q <= conflict_cnt_q + 32'd1;
        end
    end

    assign conflict_cnt_o = conflict_cnt_q;
`endif

endmodule

// File: tb/tb_riscv_mem_port_arbiter.sv
// Directed self-checking bench for riscv_mem_port_arbiter; inputs driven 1 time unit after the
// rising edge, outputs sampled 2 units after it.
module tb_riscv_mem_port_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        if_req_i, if_flush_i, if_gnt_o, if_rvalid_o;
    logic [31:0] if_addr_i, if_rdata_o;
    logic        ls_req_i, ls_we_i, ls_gnt_o, ls_rvalid_o;
    logic [3:0]  ls_be_i;
    logic [31:0] ls_addr_i, ls_wdata_i, ls_rdata_o;
    logic        mem_req_o, mem_we_o, mem_gnt_i, mem_rvalid_i;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
    logic        busy_o;
`ifdef RISCV_MEM_ARB_PERF_EN
    logic [31:0] conflict_cnt_o;
`endif

    // Memory stimulus comes either from the hand-driven signals or the auto responder.
    logic        mem_auto;
    logic        man_gnt, man_rvalid, auto_gnt, auto_rvalid;
    logic [31:0] man_rdata, auto_rdata;
    assign mem_gnt_i    = mem_auto ? auto_gnt    : man_gnt;
    assign mem_rvalid_i = mem_auto ? auto_rvalid : man_rvalid;
    assign mem_rdata_i  = mem_auto ? auto_rdata  : man_rdata;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk_i = ~clk_i;

    riscv_mem_port_arbiter #(
        .ADDR_W       (32),
        .DATA_W       (32),
        .MAX_LS_STREAK(4)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .if_req_i    (if_req_i),
        .if_addr_i   (if_addr_i),
        .if_flush_i  (if_flush_i),
        .if_gnt_o    (if_gnt_o),
        .if_rvalid_o (if_rvalid_o),
        .if_rdata_o  (if_rdata_o),
        .ls_req_i    (ls_req_i),
        .ls_we_i     (ls_we_i),
        .ls_be_i     (ls_be_i),
        .ls_addr_i   (ls_addr_i),
        .ls_wdata_i  (ls_wdata_i),
        .ls_gnt_o    (ls_gnt_o),
        .ls_rvalid_o (ls_rvalid_o),
        .ls_rdata_o  (ls_rdata_o),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o),
        .mem_be_o    (mem_be_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_gnt_i   (mem_gnt_i),
        .mem_rvalid_i(mem_rvalid_i),
        .mem_rdata_i (mem_rdata_i),
`ifdef RISCV_MEM_ARB_PERF_EN
        .conflict_cnt_o(conflict_cnt_o),
`endif
        .busy_o      (busy_o)
    );

    // Auto responder: grant in the first request cycle, respond in the following cycle.
    initial begin
        auto_gnt = 1'b0; auto_rvalid = 1'b0; auto_rdata = '0;
        forever begin
            @(posedge clk_i); #1;
            if (mem_auto && mem_req_o) begin
                auto_gnt = 1'b1;
                @(posedge clk_i); #1;
                auto_gnt = 1'b0; auto_rvalid = 1'b1; auto_rdata = 32'hC0DE_0000;
                @(posedge clk_i); #1;
                auto_rvalid = 1'b0; auto_rdata = '0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk_i); #1;
    endtask

    task automatic test_reset();
        #3;
        n_cmp++; if ({if_gnt_o, ls_gnt_o, mem_req_o, busy_o} !== 4'b0000) begin
            n_bad++; $display("FAIL reset_ctrl: got %b want 0000", {if_gnt_o, ls_gnt_o, mem_req_o, busy_o});
        end
        n_cmp++; if ({if_rvalid_o, ls_rvalid_o, mem_we_o} !== 3'b000) begin
            n_bad++; $display("FAIL reset_rvalid: got %b want 000", {if_rvalid_o, ls_rvalid_o, mem_we_o});
        end
        n_cmp++; if ({mem_addr_o, mem_be_o, mem_wdata_o} !== 68'h0) begin
            n_bad++; $display("FAIL reset_fields: got %h want 0", {mem_addr_o, mem_be_o, mem_wdata_o});
        end
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
    endtask

    task automatic test_if_only();
        tick(); if_req_i = 1'b1; if_addr_i = 32'h2800; #1;
        n_cmp++; if ({if_gnt_o, ls_gnt_o, busy_o} !== 3'b100) begin
            n_bad++; $display("FAIL if_grant: got %b want 100", {if_gnt_o, ls_gnt_o, busy_o});
        end
        tick(); if_req_i = 1'b0; if_addr_i = '0; #1;
        n_cmp++; if ({mem_req_o, mem_we_o, mem_be_o, if_gnt_o, busy_o} !== 8'b1_0_1111_0_1) begin
            n_bad++; $display("FAIL if_req_phase: got %b want 10111101", {mem_req_o, mem_we_o, mem_be_o, if_gnt_o, busy_o});
        end
        n_cmp++; if (mem_addr_o !== 32'h2800) begin
            n_bad++; $display("FAIL if_mem_addr: got %h want 00002800", mem_addr_o);
        end
        tick(); #1;
        n_cmp++; if (mem_req_o !== 1'b1) begin
            n_bad++; $display("FAIL if_req_hold: got %b want 1", mem_req_o);
        end
        man_gnt = 1'b1; tick(); man_gnt = 1'b0; #1;
        n_cmp++; if ({mem_req_o, busy_o, if_rvalid_o} !== 3'b010) begin
            n_bad++; $display("FAIL if_wait_phase: got %b want 010", {mem_req_o, busy_o, if_rvalid_o});
        end
        man_rvalid = 1'b1; man_rdata = 32'h0000_0013; #1;
        n_cmp++; if ({if_rvalid_o, ls_rvalid_o} !== 2'b10 || if_rdata_o !== 32'h13) begin
            n_bad++; $display("FAIL if_resp: got %b/%h want 10/00000013", {if_rvalid_o, ls_rvalid_o}, if_rdata_o);
        end
        tick(); man_rvalid = 1'b0; man_rdata = '0; #1;
        n_cmp++; if ({busy_o, if_rvalid_o, if_gnt_o} !== 3'b000 || if_rdata_o !== 32'h0) begin
            n_bad++; $display("FAIL if_done: got %b/%h want 000/0", {busy_o, if_rvalid_o, if_gnt_o}, if_rdata_o);
        end
    endtask

    task automatic test_ls_store();
        tick(); ls_req_i = 1'b1; ls_we_i = 1'b1; ls_be_i = 4'b0011;
        ls_addr_i = 32'h100; ls_wdata_i = 32'hDEAD_BEEF; #1;
        n_cmp++; if ({ls_gnt_o, if_gnt_o} !== 2'b10) begin
            n_bad++; $display("FAIL ls_grant: got %b want 10", {ls_gnt_o, if_gnt_o});
        end
        tick(); ls_req_i = 1'b0; ls_we_i = 1'b0; ls_be_i = '0; ls_addr_i = '0; ls_wdata_i = '0; #1;
        n_cmp++; if ({mem_req_o, mem_we_o, mem_be_o} !== 6'b1_1_0011) begin
            n_bad++; $display("FAIL ls_ctrl: got %b want 110011", {mem_req_o, mem_we_o, mem_be_o});
        end
        n_cmp++; if (mem_addr_o !== 32'h100 || mem_wdata_o !== 32'hDEAD_BEEF) begin
            n_bad++; $display("FAIL ls_fields: got %h/%h want 00000100/deadbeef", mem_addr_o, mem_wdata_o);
        end
        man_gnt = 1'b1; tick(); man_gnt = 1'b0; #1;
        man_rvalid = 1'b1; #1;
        n_cmp++; if ({ls_rvalid_o, if_rvalid_o, mem_req_o} !== 3'b100) begin
            n_bad++; $display("FAIL ls_ack: got %b want 100", {ls_rvalid_o, if_rvalid_o, mem_req_o});
        end
        tick(); man_rvalid = 1'b0; #1;
        n_cmp++; if ({ls_rvalid_o, busy_o} !== 2'b00) begin
            n_bad++; $display("FAIL ls_done: got %b want 00", {ls_rvalid_o, busy_o});
        end
    endtask

    task automatic test_flush();
        // Flush pulsed during WAIT, response arrives one cycle later.
        tick(); if_req_i = 1'b1; if_addr_i = 32'h3000; #1;
        tick(); if_req_i = 1'b0; man_gnt = 1'b1;
        tick(); man_gnt = 1'b0; if_flush_i = 1'b1;
        tick(); if_flush_i = 1'b0; man_rvalid = 1'b1; man_rdata = 32'hFFFF_FFFF; #1;
        n_cmp++; if (if_rvalid_o !== 1'b0 || if_rdata_o !== 32'h0) begin
            n_bad++; $display("FAIL flush_drop: got %b/%h want 0/0", if_rvalid_o, if_rdata_o);
        end
        tick(); man_rvalid = 1'b0; man_rdata = '0;
        // Flush coincident with the response.
        if_req_i = 1'b1; if_addr_i = 32'h3004; #1;
        n_cmp++; if (if_gnt_o !== 1'b1) begin
            n_bad++; $display("FAIL flush_regrant: got %b want 1", if_gnt_o);
        end
        tick(); if_req_i = 1'b0; man_gnt = 1'b1;
        tick(); man_gnt = 1'b0; if_flush_i = 1'b1; man_rvalid = 1'b1; man_rdata = 32'hFFFF_FFFF; #1;
        n_cmp++; if (if_rvalid_o !== 1'b0) begin
            n_bad++; $display("FAIL flush_same_cycle: got %b want 0", if_rvalid_o);
        end
        tick(); if_flush_i = 1'b0; man_rvalid = 1'b0; man_rdata = '0;
        // Normal fetch afterwards delivers its own data.
        if_req_i = 1'b1; if_addr_i = 32'h3008; #1;
        n_cmp++; if (if_gnt_o !== 1'b1) begin
            n_bad++; $display("FAIL flush_next_grant: got %b want 1", if_gnt_o);
        end
        tick(); if_req_i = 1'b0; man_gnt = 1'b1;
        tick(); man_gnt = 1'b0; man_rvalid = 1'b1; man_rdata = 32'h1234_5678; #1;
        n_cmp++; if (if_rvalid_o !== 1'b1 || if_rdata_o !== 32'h1234_5678) begin
            n_bad++; $display("FAIL flush_next_data: got %b/%h want 1/12345678", if_rvalid_o, if_rdata_o);
        end
        tick(); man_rvalid = 1'b0; man_rdata = '0;
    endtask

    task automatic test_back_to_back();
        bit exp_ls [10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
        int ng  = 0;
        int cyc = 0;
        mem_auto = 1'b1;
        tick(); if_req_i = 1'b1; ls_req_i = 1'b1; if_addr_i = 32'h4000; ls_addr_i = 32'h8000;
        while (ng < 10 && cyc < 100) begin
            #1;
            if (if_gnt_o || ls_gnt_o) begin
                n_cmp++; if (ls_gnt_o !== exp_ls[ng] || if_gnt_o !== !exp_ls[ng]) begin
                    n_bad++; $display("FAIL grant_order[%0d]: got ls=%b if=%b want ls=%b", ng, ls_gnt_o, if_gnt_o, exp_ls[ng]);
                end
                ng++;
            end
            tick(); cyc++;
        end
        if_req_i = 1'b0; ls_req_i = 1'b0;
        n_cmp++; if (ng != 10) begin
            n_bad++; $display("FAIL grant_count: got %0d want 10", ng);
        end
        cyc = 0; #1;
        while (busy_o && cyc < 20) begin tick(); #1; cyc++; end
        mem_auto = 1'b0;
    endtask

`ifdef RISCV_MEM_ARB_PERF_EN
    task automatic test_perf();
        logic [31:0] cnt0;
        int ng  = 0;
        int cyc = 0;
        mem_auto = 1'b1;
        tick(); cnt0 = conflict_cnt_o; if_req_i = 1'b1; ls_req_i = 1'b1;
        while (ng < 10 && cyc < 100) begin
            #1;
            if (if_gnt_o || ls_gnt_o) ng++;
            tick(); cyc++;
        end
        if_req_i = 1'b0; ls_req_i = 1'b0;
        cyc = 0; #1;
        while (busy_o && cyc < 20) begin tick(); #1; cyc++; end
        mem_auto = 1'b0;
        n_cmp++; if (conflict_cnt_o !== cnt0 + 32'd10) begin
            n_bad++; $display("FAIL perf_conflict: got %0d want %0d", conflict_cnt_o, cnt0 + 32'd10);
        end
    endtask
`endif

    task automatic test_reset_mid_wait();
        tick(); if_req_i = 1'b1; if_addr_i = 32'h5000; #1;
        tick(); if_req_i = 1'b0; man_gnt = 1'b1;
        tick(); man_gnt = 1'b0; #1;
        n_cmp++; if (busy_o !== 1'b1) begin
            n_bad++; $display("FAIL rst_pre_wait: got %b want 1", busy_o);
        end
        rst_ni = 1'b0; if_req_i = 1'b1; ls_req_i = 1'b1; #1;
        n_cmp++; if ({mem_req_o, busy_o, if_gnt_o, ls_gnt_o, if_rvalid_o, ls_rvalid_o} !== 6'b0) begin
            n_bad++; $display("FAIL rst_async: got %b want 000000", {mem_req_o, busy_o, if_gnt_o, ls_gnt_o, if_rvalid_o, ls_rvalid_o});
        end
        tick(); if_req_i = 1'b0; ls_req_i = 1'b0; rst_ni = 1'b1;
        man_rvalid = 1'b1; man_rdata = 32'hBAD0_BAD0; #1;
        n_cmp++; if ({if_rvalid_o, ls_rvalid_o, busy_o} !== 3'b000 || if_rdata_o !== 32'h0) begin
            n_bad++; $display("FAIL rst_stray_rvalid: got %b/%h want 000/0", {if_rvalid_o, ls_rvalid_o, busy_o}, if_rdata_o);
        end
        tick(); man_rvalid = 1'b0; man_rdata = '0; #1;
        n_cmp++; if ({busy_o, mem_req_o} !== 2'b00) begin
            n_bad++; $display("FAIL rst_idle: got %b want 00", {busy_o, mem_req_o});
        end
    endtask

    initial begin
        rst_ni = 1'b0;
        if_req_i = 1'b0; if_addr_i = '0; if_flush_i = 1'b0;
        ls_req_i = 1'b0; ls_we_i = 1'b0; ls_be_i = '0; ls_addr_i = '0; ls_wdata_i = '0;
        mem_auto = 1'b0; man_gnt = 1'b0; man_rvalid = 1'b0; man_rdata = '0;
        test_reset();
        test_if_only();
        test_ls_store();
        test_flush();
        test_back_to_back();
`ifdef RISCV_MEM_ARB_PERF_EN
        test_perf();
`endif
        test_reset_mid_wait();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
